// File: rtl/mips_pipe_param.sv
// mips_pipe_param: four-stage MIPS-subset pipeline with a parametrised register file.
//   S1 input register -> S2 decode/operand read (with EX forwarding) -> S3 execute and
//   register write -> S4 report of NUM_OUT selected registers -> registered outputs.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid          instruction/output_reg valid this cycle (0 = bubble)
//   instruction       32-bit MIPS word
//   output_reg        NUM_OUT x 5-bit register indices to report
//   out_valid         outputs valid
//   instruction_fail  illegal instruction, destination or reported index
//   out_data          NUM_OUT x DW register values (0 on fail)
module mips_pipe_param #(
    parameter int DW       = 32,
    parameter int NUM_REGS = 8,
    parameter int NUM_OUT  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [31:0]           instruction,
    input  logic [NUM_OUT*5-1:0]  output_reg,
    output logic                  out_valid,
    output logic                  instruction_fail,
    output logic [NUM_OUT*DW-1:0] out_data
);
    function automatic logic idx_ok(input logic [4:0] idx);
        return {27'd0, idx} < NUM_REGS;
    endfunction

    // Pipeline registers
    logic                 r_s1_valid, r_s2_valid, r_s3_valid, r_s4_valid;
    logic [31:0]          r_s1_instr, r_s2_instr;
    logic [NUM_OUT*5-1:0] r_s1_oreg, r_s2_oreg, r_s3_oreg, r_s4_oreg;
    logic                 r_s3_fail, r_s4_fail;
    logic [5:0]           r_s3_op;
    logic [4:0]           r_s3_rt;
    logic [15:0]          r_s3_imm;
    logic [DW-1:0]        r_s3_a, r_s3_b;
    logic                 r_out_valid, r_out_fail;
    logic [NUM_OUT*DW-1:0] r_out_data;

    // Register file view: indices at or beyond NUM_REGS read as 0 (and are flagged as fail)
    logic [DW-1:0] w_regs [32];

    // S3 execute results
    logic [DW-1:0] w_s3_res;
    logic [4:0]    w_s3_dest;
    logic          w_s3_bad;
    logic          w_s3_fail;
    logic          w_s3_wr;
    logic [DW-1:0] w_imm_sx, w_imm_zx;

    assign w_imm_sx = DW'($signed(r_s3_imm));
    assign w_imm_zx = DW'(r_s3_imm);

    // Shifts by shamt >= DW naturally yield 0 for logical shifts on a DW-bit operand.
    always_comb begin
        w_s3_res  = '0;
        w_s3_bad  = 1'b0;
        w_s3_dest = r_s3_rt;
        case (r_s3_op)
            6'b000000: begin
                w_s3_dest = r_s3_imm[15:11];
                case (r_s3_imm[5:0])
                    6'b100000: w_s3_res = r_s3_a + r_s3_b;
                    6'b100010: w_s3_res = r_s3_a - r_s3_b;
                    6'b100100: w_s3_res = r_s3_a & r_s3_b;
                    6'b100101: w_s3_res = r_s3_a | r_s3_b;
                    6'b100111: w_s3_res = ~(r_s3_a | r_s3_b);
                    6'b101010: w_s3_res = ($signed(r_s3_a) < $signed(r_s3_b)) ? DW'(1) : '0;
                    6'b000000: w_s3_res = r_s3_b << r_s3_imm[10:6];
                    6'b000010: w_s3_res = r_s3_b >> r_s3_imm[10:6];
                    default:   w_s3_bad = 1'b1;
                endcase
            end
            6'b001000: w_s3_res = r_s3_a + w_imm_sx;
            6'b001100: w_s3_res = r_s3_a & w_imm_zx;
            6'b001101: w_s3_res = r_s3_a | w_imm_zx;
            default:   w_s3_bad = 1'b1;
        endcase
    end

    assign w_s3_fail = r_s3_fail | w_s3_bad | ~idx_ok(w_s3_dest);
    // Only a valid, non-failing instruction writes and acts as a forwarding source.
    assign w_s3_wr   = r_s3_valid & ~w_s3_fail;

    // Register file storage
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_rf
            if (gi < NUM_REGS) begin : g_reg
                logic [DW-1:0] r_val;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)
                        r_val <= '0;
                    else if (w_s3_wr && w_s3_dest == 5'(gi))
                        r_val <= w_s3_res;
                end
                assign w_regs[gi] = r_val;
            end else begin : g_none
                assign w_regs[gi] = '0;
            end
        end
    endgenerate

    // S2 decode with forwarding from the instruction currently in S3
    logic [4:0]    w_rs, w_rt;
    logic          w_s2_fail;
    logic [DW-1:0] w_s2_a, w_s2_b;

    assign w_rs      = r_s2_instr[25:21];
    assign w_rt      = r_s2_instr[20:16];
    assign w_s2_fail = ~idx_ok(w_rs) | ~idx_ok(w_rt);
    assign w_s2_a    = (w_s3_wr && w_s3_dest == w_rs) ? w_s3_res : w_regs[w_rs];
    assign w_s2_b    = (w_s3_wr && w_s3_dest == w_rt) ? w_s3_res : w_regs[w_rt];

    // S4 report read: the register file already holds this instruction's write
    logic [NUM_OUT*DW-1:0] w_rd_data;
    logic [NUM_OUT-1:0]    w_oreg_bad;

    generate
        for (gi = 0; gi < NUM_OUT; gi++) begin : g_out
            assign w_rd_data[gi*DW +: DW] = w_regs[r_s4_oreg[gi*5 +: 5]];
            assign w_oreg_bad[gi]         = ~idx_ok(r_s4_oreg[gi*5 +: 5]);
        end
    endgenerate

    logic w_s4_fail;
    assign w_s4_fail = r_s4_fail | (|w_oreg_bad);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_instr  <= '0;
            r_s1_oreg   <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_instr  <= '0;
            r_s2_oreg   <= '0;
            r_s3_valid  <= 1'b0;
            r_s3_fail   <= 1'b0;
            r_s3_op     <= '0;
            r_s3_rt     <= '0;
            r_s3_imm    <= '0;
            r_s3_a      <= '0;
            r_s3_b      <= '0;
            r_s3_oreg   <= '0;
            r_s4_valid  <= 1'b0;
            r_s4_fail   <= 1'b0;
            r_s4_oreg   <= '0;
            r_out_valid <= 1'b0;
            r_out_fail  <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_s1_valid  <= in_valid;
            r_s1_instr  <= instruction;
            r_s1_oreg   <= output_reg;
            r_s2_valid  <= r_s1_valid;
            r_s2_instr  <= r_s1_instr;
            r_s2_oreg   <= r_s1_oreg;
            r_s3_valid  <= r_s2_valid;
            r_s3_fail   <= r_s2_valid & w_s2_fail;
            r_s3_op     <= r_s2_instr[31:26];
            r_s3_rt     <= r_s2_instr[20:16];
            r_s3_imm    <= r_s2_instr[15:0];
            r_s3_a      <= w_s2_a;
            r_s3_b      <= w_s2_b;
            r_s3_oreg   <= r_s2_oreg;
            r_s4_valid  <= r_s3_valid;
            r_s4_fail   <= r_s3_valid & w_s3_fail;
            r_s4_oreg   <= r_s3_oreg;
            // Bubbles report all-zero outputs regardless of their content
            r_out_valid <= r_s4_valid;
            r_out_fail  <= r_s4_valid & w_s4_fail;
            r_out_data  <= (r_s4_valid && !w_s4_fail) ? w_rd_data : '0;
        end
    end

    assign out_valid        = r_out_valid;
    assign instruction_fail = r_out_fail;
    assign out_data         = r_out_data;
endmodule

// File: tb/tb_mips_pipe_param.sv
module tb_mips_pipe_param;
    localparam int DW = 32;
    localparam int NR = 8;
    localparam int NO = 3;
    localparam int OW = NO * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [31:0]   instruction = '0;
    logic [NO*5-1:0] output_reg = '0;
    logic          out_valid;
    logic          instruction_fail;
    logic [OW-1:0] out_data;

    mips_pipe_param #(.DW(DW), .NUM_REGS(NR), .NUM_OUT(NO)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .instruction(instruction),
        .output_reg(output_reg), .out_valid(out_valid),
        .instruction_fail(instruction_fail), .out_data(out_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic          f;
        logic [OW-1:0] d;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_regs [32];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s t=%0t got=%h want=%h", tag, $time, got, want);
        end
    endtask

    function automatic logic [31:0] r_ins(int f, int rs, int rt, int rd, int sh);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(f)};
    endfunction

    function automatic logic [31:0] i_ins(int op, int rs, int rt, int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [NO*5-1:0] oregs(int a, int b, int c);
        return {5'(c), 5'(b), 5'(a)};
    endfunction

    // Architectural reference: instructions execute one at a time, in order.
    task automatic predict(input logic v, input logic [31:0] ins, input logic [NO*5-1:0] oreg,
                           output exp_t e);
        int unsigned op, rs, rt, rd, sh, fn, dest, idx;
        logic [31:0] a, b, res, immsx, immzx;
        logic bad;
        e.v = 1'b0; e.f = 1'b0; e.d = '0;
        if (!v) return;
        op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
        sh = ins[10:6];  fn = ins[5:0];
        a = m_regs[rs]; b = m_regs[rt];
        immsx = {{16{ins[15]}}, ins[15:0]};
        immzx = {16'd0, ins[15:0]};
        bad = (rs >= NR) || (rt >= NR);
        res = '0; dest = rt;
        case (op)
            0: begin
                dest = rd;
                case (fn)
                    32: res = a + b;
                    34: res = a - b;
                    36: res = a & b;
                    37: res = a | b;
                    39: res = ~(a | b);
                    42: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    0:  res = (sh >= DW) ? 32'd0 : (b << sh);
                    2:  res = (sh >= DW) ? 32'd0 : (b >> sh);
                    default: bad = 1'b1;
                endcase
            end
            8:  res = a + immsx;
            12: res = a & immzx;
            13: res = a | immzx;
            default: bad = 1'b1;
        endcase
        if (dest >= NR) bad = 1'b1;
        if (!bad) m_regs[dest] = res;
        for (int k = 0; k < NO; k++) begin
            idx = oreg[k*5 +: 5];
            if (idx >= NR) bad = 1'b1;
            e.d[k*DW +: DW] = m_regs[idx];
        end
        e.v = 1'b1;
        e.f = bad;
        if (bad) e.d = '0;
    endtask

    task automatic push_idle(int n);
        exp_t z;
        z.v = 1'b0; z.f = 1'b0; z.d = '0;
        for (int i = 0; i < n; i++) exp_q.push_back(z);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        exp_q.delete();
        push_idle(4);
    endtask

    // One cycle: drive a slot, then compare the output due for the slot 4 edges back.
    task automatic step(input logic v, input logic [31:0] ins, input logic [NO*5-1:0] oreg);
        exp_t e;
        predict(v, ins, oreg, e);
        exp_q.push_back(e);
        in_valid    = v;
        instruction = ins;
        output_reg  = oreg;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("out_valid", OW'(out_valid), OW'(e.v));
        chk("instruction_fail", OW'(instruction_fail), OW'(e.f));
        chk("out_data", out_data, e.d);
        if (out_valid)
            $display("txn t=%0t fail=%0b data=%h", $time, instruction_fail, out_data);
    endtask

    task automatic bubble();
        step(1'b0, $urandom, oregs(0, 0, 0));
    endtask

    task automatic drain();
        repeat (4) bubble();
    endtask

    function automatic logic [31:0] rand_ins();
        int kind, rs, rt, rd;
        int fns[8] = '{32, 34, 36, 37, 39, 42, 0, 2};
        kind = $urandom_range(0, 12);
        rs = ($urandom_range(0, 15) == 0) ? $urandom_range(8, 31) : $urandom_range(0, 7);
        rt = ($urandom_range(0, 15) == 0) ? $urandom_range(8, 31) : $urandom_range(0, 7);
        rd = ($urandom_range(0, 15) == 0) ? $urandom_range(8, 31) : $urandom_range(0, 7);
        if (kind < 8)  return r_ins(fns[kind], rs, rt, rd, $urandom_range(0, 31));
        if (kind == 8) return i_ins(8, rs, rt, $urandom);
        if (kind == 9) return i_ins(12, rs, rt, $urandom);
        if (kind == 10) return i_ins(13, rs, rt, $urandom);
        if (kind == 11) return r_ins(41, rs, rt, rd, 0);
        return i_ins(35, rs, rt, $urandom);
    endfunction

    function automatic logic [NO*5-1:0] rand_oreg();
        logic [NO*5-1:0] o;
        for (int k = 0; k < NO; k++)
            o[k*5 +: 5] = ($urandom_range(0, 19) == 0) ? 5'($urandom_range(8, 31))
                                                       : 5'($urandom_range(0, 7));
        return o;
    endfunction

    initial begin
        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", OW'(out_valid), '0);
        chk("rst_fail", OW'(instruction_fail), '0);
        chk("rst_data", out_data, '0);
        rst_n = 1'b1;

        // First instruction after reset
        step(1'b1, i_ins(8, 0, 1, 5), oregs(1, 0, 0));
        drain();
        chk("addi_r1", out_data[31:0], 32'd5);

        // Back-to-back dependency through forwarding, then re-read two slots later
        step(1'b1, i_ins(8, 0, 1, 5), oregs(2, 0, 0));
        step(1'b1, r_ins(32, 1, 1, 2, 0), oregs(2, 0, 0));
        drain();
        chk("fwd_add", out_data[31:0], 32'd10);
        step(1'b1, i_ins(8, 0, 1, 5), oregs(1, 0, 0));
        step(1'b1, r_ins(32, 1, 1, 2, 0), oregs(2, 1, 0));
        bubble();
        step(1'b1, r_ins(32, 1, 0, 6, 0), oregs(6, 1, 2));

        // Immediate extension
        step(1'b1, i_ins(8, 1, 1, 16'hFFFF), oregs(1, 0, 0));
        step(1'b1, i_ins(12, 1, 3, 16'hFFFF), oregs(3, 1, 0));
        step(1'b1, i_ins(13, 0, 3, 16'h8000), oregs(3, 0, 0));
        drain();
        chk("ori_zx", out_data[31:0], 32'h0000_8000);

        // ALU ops with r1=5, r2=10
        step(1'b1, i_ins(8, 0, 1, 5), oregs(1, 0, 0));
        step(1'b1, i_ins(8, 0, 2, 10), oregs(2, 1, 0));
        step(1'b1, r_ins(34, 1, 2, 3, 0), oregs(3, 0, 0));
        drain();
        chk("sub_neg", out_data[31:0], 32'hFFFF_FFFB);
        step(1'b1, r_ins(42, 1, 2, 4, 0), oregs(4, 0, 0));
        step(1'b1, r_ins(42, 2, 1, 4, 0), oregs(4, 0, 0));
        step(1'b1, r_ins(0, 0, 1, 5, 4), oregs(5, 0, 0));
        step(1'b1, r_ins(2, 0, 1, 5, 1), oregs(5, 4, 0));
        drain();
        chk("srl", out_data[31:0], 32'd2);

        // Illegal indices
        step(1'b1, r_ins(32, 1, 1, 9, 0), oregs(1, 2, 0));
        step(1'b1, r_ins(32, 9, 1, 2, 0), oregs(2, 0, 0));
        drain();
        chk("bad_src_fail", OW'(instruction_fail), OW'(1));
        chk("bad_src_data", out_data, '0);
        step(1'b1, i_ins(8, 1, 1, 1), oregs(1, 12, 0));
        step(1'b1, i_ins(8, 0, 0, 0), oregs(1, 0, 0));
        drain();
        chk("oreg_write", out_data[31:0], 32'd6);

        // Bubble between dependent instructions
        step(1'b1, i_ins(8, 0, 6, 7), oregs(6, 0, 0));
        step(1'b0, i_ins(8, 0, 6, 99), oregs(6, 0, 0));
        step(1'b1, r_ins(32, 6, 6, 7, 0), oregs(7, 6, 0));
        drain();
        chk("bubble_dep", out_data[31:0], 32'd14);

        // Reset with three instructions in flight
        step(1'b1, i_ins(8, 0, 1, 11), oregs(1, 0, 0));
        step(1'b1, i_ins(8, 0, 2, 12), oregs(2, 0, 0));
        step(1'b1, i_ins(8, 0, 3, 13), oregs(3, 0, 0));
        rst_n = 1'b0;
        in_valid = 1'b0;
        #2;
        chk("midrst_valid", OW'(out_valid), '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        step(1'b1, i_ins(8, 0, 0, 0), oregs(1, 2, 3));
        drain();
        chk("midrst_regs", out_data, '0);

        // Randomised traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 6) == 0) bubble();
            else step(1'b1, rand_ins(), rand_oreg());
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mips_pipe_param.md
# mips_pipe_param

Parametrised four-stage MIPS-subset pipeline: the next generation of the team's fixed three-output MIPS pipe. It takes one instruction per cycle and executes it against an internal register file of configurable depth and data width. After each instruction it reports NUM_OUT selected registers. Compared with the previous generation it adds:
- EX-to-decode forwarding,
- bubble suppression on invalid cycles,
- sub/slt/andi/ori,
- a sign-extended addi immediate.

## Interface
- DW, 32, data/register width (8..32)
- NUM_REGS, 8, register file depth; index r is valid iff r < NUM_REGS (1..32)
- NUM_OUT, 3, number of reported registers per instruction (1..8)

- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction/output_reg are valid this cycle
- instruction  in  32  MIPS word
- output_reg  in  NUM_OUT*5  slice k ([5k+4:5k]) = index of register reported on out_data slice k
- out_valid  out  1  out_data/instruction_fail valid
- instruction_fail  out  1  instruction or any output_reg index was illegal
- out_data  out  NUM_OUT*DW  slice k ([DW*k+DW-1:DW*k]) = value of register output_reg slice k

## Operation
- Stage S1: registers instruction, output_reg and in_valid; no other work.
- Stage S2 (decode):
  - Read rs=[25:21] and rt=[20:16]; flag fail on any index ≥ NUM_REGS.
  - Forwarding: if the instruction in S3 is valid, non-failing and its destination equals a source, S2 uses the S3 result instead of the register file.
- Stage S3 (execute/write-back):
  - R-type (opcode 000000), dest rd=[15:11], funct [5:0]:
    - add 100000 = rs+rt; sub 100010 = rs−rt
    - and 100100; or 100101; nor 100111 = ~(rs|rt)
    - slt 101010 = (signed rs < signed rt) ? 1 : 0
    - sll 000000 = rt << shamt[10:6]; srl 000010 = rt >> shamt (logical)
  - I-type, dest rt:
    - addi 001000: rs + sign-extended imm[15:0]
    - andi 001100: rs & zero-extended imm
    - ori 001101: rs | zero-extended imm
  - Fail on any other opcode/funct, on an invalid destination, or on an S2 fail.
  - The write occurs at the end of S3 only if the instruction is valid and not failed.
- Stage S4 (report):
  - Read each output_reg slice from the register file, which already holds this instruction's write.
  - Any slice index ≥ NUM_REGS sets fail.
  - On fail: out_data=0 and instruction_fail=1.
- Arithmetic and width rules:
  - Arithmetic is modulo 2^DW.
  - Immediates are extended or truncated to DW.
  - Shift by shamt ≥ DW gives 0.
  - Register 0 is an ordinary writable register, not hardwired to zero.
- Invalid cycles (in_valid=0) are bubbles:
  - no write, no forwarding source;
  - out_valid=0, instruction_fail=0 and out_data=0 at S4;
  - their instruction content is ignored, including fail checks.

## Timing
- Latency: an instruction sampled with in_valid at edge k produces out_valid=1 after edge k+4. Throughput is one instruction per cycle, with no stalls.
- Hazard timing for instruction i (register write at edge k+3):
  - i+1 reads via forwarding;
  - i+2 and later read the updated register file;
  - every case returns the new value.
- A failed instruction neither writes nor forwards, so a dependent successor sees the older value.
- Reset: all pipeline registers and all NUM_REGS registers go to 0. Outputs are out_valid=0, instruction_fail=0, out_data=0.
- Reset mid-operation aborts in-flight instructions with no output. The first instruction after release appears 4 edges after it is sampled.
- Outputs are registered and change only on clk rising edge or on reset.

## Test plan
(Defaults apply: DW=32, NUM_REGS=8, NUM_OUT=3; out_data slices are listed as {out_1,out_2,out_3}.)
- Reset, then addi r1,r0,5 with output_reg {r1,r0,r0}, 4 cycles later -> out_valid=1, fail=0, out_data {5,0,0}; all outputs were 0 before.
- Back-to-back dependent pair, both reporting r2:
  - Stimulus: addi r1,r0,5 then add r2,r1,r1 on consecutive cycles.
  - Required response: the second reports 10 (forwarding); r1 is read correctly again two cycles later.
- Immediate extension, starting from r1=5:
  - addi r1,r1,0xFFFF -> r1=4 (sign extension).
  - andi r3,r1,0xFFFF -> r3=4.
  - ori r3,r0,0x8000 -> r3=0x00008000 (zero extension).
- r1=5, r2=10:
  - sub r3,r1,r2 -> 0xFFFFFFFB.
  - slt r4,r1,r2 -> 1; slt r4,r2,r1 -> 0.
  - sll r5,r1,4 -> 0x50; srl r5,r1,1 -> 2.
- Illegal indices:
  - add r9,r1,r1 -> instruction_fail=1, out_data=0, no write; a following add r2,r9,r1 also fails.
  - A legal addi r1,r1,1 whose output_reg contains index 12 -> instruction_fail=1, yet r1 is written (visible in the next report).
- Bubble and reset:
  - A garbage instruction with in_valid=0 placed between dependent instructions -> no write, out_valid=0 in that slot.
  - rst_n asserted while 3 instructions are in flight -> no out_valid and all registers read 0 afterwards.
